ypc_ctrl_fsm: RTL and testbench

//  Multi-cycle sequencer for the YPC core datapath (PC, instruction fetch, decoder, register file).

---
 rtl/ypc_pkg.sv | 18 +
 rtl/ypc_fetch_wdog.sv | 29 ++
 rtl/ypc_ctrl_fsm.sv | 127 ++++++++++++
 tb/tb_ypc_ctrl_fsm.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ypc_pkg.sv
// Shared definitions for the YPC core sequencer: state encoding, datapath width, reset PC.
package ypc_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int          TIMEOUT_DEFAULT  = 255;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    WAIT   = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    FAULT  = 3'd6
  } state_e;

endpackage

// File: rtl/ypc_fetch_wdog.sv
// Fetch-wait watchdog, only instantiated when YPC_FETCH_TIMEOUT_EN is defined.
// expired_o is raised during the LIMIT-th consecutive WAIT cycle.
module ypc_fetch_wdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 8'd0;
    end else if (clear_i) begin
      cnt_q <= 8'd0;
    end else if (count_i && cnt_q != 8'hFF) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign expired_o = count_i && (cnt_q == LAST);

endmodule

// File: rtl/ypc_ctrl_fsm.sv
// Multi-cycle FETCH/WAIT/DECODE/EXEC/WB sequencer for the YPC core.
// Optional fetch-wait watchdog enabled by defining YPC_FETCH_TIMEOUT_EN.
module ypc_ctrl_fsm #(
  parameter logic [31:0] RESET_PC       = ypc_pkg::RESET_PC_DEFAULT,
  parameter int          XLEN           = ypc_pkg::XLEN,
  parameter int          TIMEOUT_CYCLES = ypc_pkg::TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_vld,
  input  logic            imem_req_rdy,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_vld,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     inst,
  input  logic            dec_isbreak,
  input  logic            dec_illegal,
  input  logic            dec_regwen,
  input  logic [XLEN-1:0] ex_result,
  output logic            rf_wen,
  output logic [XLEN-1:0] rf_wdata,
  output logic [XLEN-1:0] pc,
  output logic            halt,
  output logic            fault,
  output logic [XLEN-1:0] ret,
  output logic [31:0]     instret,
  output logic [2:0]      dbg_state_o
);

  import ypc_pkg::*;

  if (XLEN != 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
    $error("ypc_ctrl_fsm: unsupported XLEN or TIMEOUT_CYCLES");
  end

  state_e            state_q;
  logic [XLEN-1:0]   pc_q;
  logic [31:0]       inst_q;
  logic              rf_wen_q;
  logic [XLEN-1:0]   rf_wdata_q;
  logic              halt_q;
  logic              fault_q;
  logic [XLEN-1:0]   ret_q;
  logic [31:0]       instret_q;
  logic              timeout;

`ifdef YPC_FETCH_TIMEOUT_EN
  ypc_fetch_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .clear_i   ((state_q == FETCH) && imem_req_rdy),
    .count_i   (state_q == WAIT),
    .expired_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Handshakes: a request transfers on a cycle where imem_req_vld && imem_req_rdy;
  // vld stays high with a stable address until then. A response is taken only in
  // WAIT, on any cycle with imem_rsp_vld high; it has no backpressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      inst_q     <= 32'd0;
      rf_wen_q   <= 1'b0;
      rf_wdata_q <= '0;
      halt_q     <= 1'b0;
      fault_q    <= 1'b0;
      ret_q      <= '0;
      instret_q  <= 32'd0;
    end else begin
      rf_wen_q <= 1'b0;
      case (state_q)
        FETCH: if (imem_req_rdy) state_q <= WAIT;
        WAIT: begin
          // A response in the same cycle the watchdog expires still wins.
          if (imem_rsp_vld) begin
            inst_q  <= imem_rsp_data;
            state_q <= DECODE;
          end else if (timeout) begin
            fault_q <= 1'b1;
            state_q <= FAULT;
          end
        end
        DECODE: begin
          if (dec_illegal) begin
            fault_q <= 1'b1;
            state_q <= FAULT;
          end else if (dec_isbreak) begin
            halt_q    <= 1'b1;
            instret_q <= instret_q + 32'd1;
            state_q   <= HALT;
          end else begin
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rf_wdata_q <= ex_result;
          rf_wen_q   <= dec_regwen;
          state_q    <= WB;
        end
        WB: begin
          if (rf_wen_q) ret_q <= rf_wdata_q;
          pc_q      <= pc_q + XLEN'(4);
          instret_q <= instret_q + 32'd1;
          state_q   <= FETCH;
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign imem_req_vld = (state_q == FETCH);
  assign imem_addr    = pc_q;
  assign inst         = inst_q;
  assign rf_wen       = rf_wen_q;
  assign rf_wdata     = rf_wdata_q;
  assign pc           = pc_q;
  assign halt         = halt_q;
  assign fault        = fault_q;
  assign ret          = ret_q;
  assign instret      = instret_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_ypc_ctrl_fsm.sv
// Directed testbench for ypc_ctrl_fsm; watchdog scenario follows YPC_FETCH_TIMEOUT_EN.
module tb_ypc_ctrl_fsm;
  import ypc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_rdy, imem_rsp_vld;
  logic [31:0] imem_rsp_data, ex_result;
  logic        dec_isbreak, dec_illegal, dec_regwen;

  logic        imem_req_vld, rf_wen, halt, fault;
  logic [31:0] imem_addr, inst, rf_wdata, pc, ret, instret;
  logic [2:0]  dbg_state;

  logic        w_imem_req_vld, w_rf_wen, w_halt, w_fault;
  logic [31:0] w_imem_addr, w_inst, w_rf_wdata, w_pc, w_ret, w_instret;
  logic [2:0]  w_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int wen_cnt  = 0;
  int req_cnt  = 0;

  // clock / reset
  always #5 clk = ~clk;

  ypc_ctrl_fsm u_dut (
    .clk(clk), .reset(reset),
    .imem_req_vld(imem_req_vld), .imem_req_rdy(imem_req_rdy), .imem_addr(imem_addr),
    .imem_rsp_vld(imem_rsp_vld), .imem_rsp_data(imem_rsp_data), .inst(inst),
    .dec_isbreak(dec_isbreak), .dec_illegal(dec_illegal), .dec_regwen(dec_regwen),
    .ex_result(ex_result), .rf_wen(rf_wen), .rf_wdata(rf_wdata), .pc(pc),
    .halt(halt), .fault(fault), .ret(ret), .instret(instret), .dbg_state_o(dbg_state)
  );

  ypc_ctrl_fsm #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset),
    .imem_req_vld(w_imem_req_vld), .imem_req_rdy(imem_req_rdy), .imem_addr(w_imem_addr),
    .imem_rsp_vld(imem_rsp_vld), .imem_rsp_data(imem_rsp_data), .inst(w_inst),
    .dec_isbreak(dec_isbreak), .dec_illegal(dec_illegal), .dec_regwen(dec_regwen),
    .ex_result(ex_result), .rf_wen(w_rf_wen), .rf_wdata(w_rf_wdata), .pc(w_pc),
    .halt(w_halt), .fault(w_fault), .ret(w_ret), .instret(w_instret), .dbg_state_o(w_dbg_state)
  );

  always @(negedge clk) begin
    if (rf_wen) wen_cnt++;
    if (imem_req_vld && imem_req_rdy) req_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "global timeout");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_req_rdy  = 1'b0;
    imem_rsp_vld  = 1'b0;
    imem_rsp_data = 32'd0;
    dec_isbreak   = 1'b0;
    dec_illegal   = 1'b0;
    dec_regwen    = 1'b0;
    ex_result     = 32'd0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  task automatic do_inst(input logic [31:0] data, input logic brk, input logic ill,
                         input logic wen, input logic [31:0] res,
                         output logic [31:0] addr_seen, output logic [31:0] inst_seen,
                         output logic wen_seen, output logic [31:0] wdata_seen);
    addr_seen    = imem_addr;
    imem_req_rdy = 1'b1;
    step();
    imem_req_rdy  = 1'b0;
    imem_rsp_vld  = 1'b1;
    imem_rsp_data = data;
    step();
    imem_rsp_vld = 1'b0;
    inst_seen    = inst;
    dec_isbreak  = brk;
    dec_illegal  = ill;
    dec_regwen   = wen;
    step();
    wen_seen   = 1'b0;
    wdata_seen = 32'd0;
    if (!brk && !ill) begin
      ex_result = res;
      step();
      wen_seen   = rf_wen;
      wdata_seen = rf_wdata;
      idle_inputs();
      step();
    end else begin
      idle_inputs();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    #23;
    n_checks++; if (pc !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h8000_0000); end
    n_checks++; if (dbg_state !== FETCH) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, FETCH); end
    n_checks++; if ({rf_wen, halt, fault} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {rf_wen, halt, fault}); end
    n_checks++; if ({inst, ret, instret, rf_wdata} !== 128'd0) begin n_fail++; $display("FAIL reset_regs: got %h expected 0", {inst, ret, instret, rf_wdata}); end
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  task automatic test_program();
    logic [31:0] insts [4];
    logic [31:0] a, iv, wd;
    logic        we;
    int          wen0;
    insts = '{32'h0010_0093, 32'h0020_8113, 32'h0031_0193, 32'h0010_0073};
    do_reset();
    wen0 = wen_cnt;
    for (int i = 0; i < 4; i++) begin
      do_inst(insts[i], i == 3, 1'b0, i != 3, 32'(i + 1), a, iv, we, wd);
      n_checks++; if (a !== 32'h8000_0000 + 32'(4 * i)) begin n_fail++; $display("FAIL prog_addr%0d: got %h expected %h", i, a, 32'h8000_0000 + 32'(4 * i)); end
      n_checks++; if (iv !== insts[i]) begin n_fail++; $display("FAIL prog_inst%0d: got %h expected %h", i, iv, insts[i]); end
      if (i != 3) begin
        n_checks++; if (we !== 1'b1 || wd !== 32'(i + 1)) begin n_fail++; $display("FAIL prog_wb%0d: got %b/%h expected 1/%h", i, we, wd, 32'(i + 1)); end
        n_checks++; if (ret !== 32'(i + 1)) begin n_fail++; $display("FAIL prog_ret%0d: got %h expected %h", i, ret, 32'(i + 1)); end
      end
    end
    n_checks++; if (halt !== 1'b1 || fault !== 1'b0) begin n_fail++; $display("FAIL prog_halt: got halt=%b fault=%b expected 1/0", halt, fault); end
    n_checks++; if (instret !== 32'd4) begin n_fail++; $display("FAIL prog_instret: got %0d expected 4", instret); end
    n_checks++; if (wen_cnt - wen0 !== 3) begin n_fail++; $display("FAIL prog_wen_pulses: got %0d expected 3", wen_cnt - wen0); end
    n_checks++; if (pc !== 32'h8000_000C) begin n_fail++; $display("FAIL prog_pc_halt: got %h expected %h", pc, 32'h8000_000C); end
    repeat (3) step();
    n_checks++; if (dbg_state !== HALT || imem_req_vld !== 1'b0) begin n_fail++; $display("FAIL prog_terminal: got state=%0d vld=%b expected %0d/0", dbg_state, imem_req_vld, HALT); end
  endtask

  task automatic test_req_backpressure();
    int req0;
    do_reset();
    req0 = req_cnt;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (imem_req_vld !== 1'b1 || imem_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL bp_hold%0d: got vld=%b addr=%h expected 1/%h", i, imem_req_vld, imem_addr, 32'h8000_0000); end
      step();
    end
    imem_req_rdy = 1'b1;
    step();
    imem_req_rdy = 1'b1;
    repeat (2) step();
    imem_req_rdy = 1'b0;
    n_checks++; if (dbg_state !== WAIT || imem_req_vld !== 1'b0) begin n_fail++; $display("FAIL bp_wait: got state=%0d vld=%b expected %0d/0", dbg_state, imem_req_vld, WAIT); end
    n_checks++; if (req_cnt - req0 !== 1) begin n_fail++; $display("FAIL bp_one_req: got %0d expected 1", req_cnt - req0); end
  endtask

  task automatic test_illegal();
    logic [31:0] a, iv, wd;
    logic        we;
    int          wen0;
    do_reset();
    wen0 = wen_cnt;
    do_inst(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 32'h55, a, iv, we, wd);
    repeat (3) step();
    n_checks++; if (fault !== 1'b1 || halt !== 1'b0) begin n_fail++; $display("FAIL ill_flags: got fault=%b halt=%b expected 1/0", fault, halt); end
    n_checks++; if (pc !== 32'h8000_0000) begin n_fail++; $display("FAIL ill_pc: got %h expected %h", pc, 32'h8000_0000); end
    n_checks++; if (wen_cnt !== wen0 || instret !== 32'd0) begin n_fail++; $display("FAIL ill_no_retire: got wen=%0d instret=%0d expected %0d/0", wen_cnt, instret, wen0); end
    n_checks++; if (dbg_state !== FAULT || imem_req_vld !== 1'b0) begin n_fail++; $display("FAIL ill_terminal: got state=%0d vld=%b expected %0d/0", dbg_state, imem_req_vld, FAULT); end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] a, iv, wd;
    logic        we;
    do_reset();
    n_checks++; if (w_imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr: got %h expected %h", w_imem_addr, 32'hFFFF_FFFC); end
    do_inst(32'h0050_0093, 1'b0, 1'b0, 1'b1, 32'd5, a, iv, we, wd);
    n_checks++; if (w_pc !== 32'd0 || w_instret !== 32'd1) begin n_fail++; $display("FAIL wrap_pc: got pc=%h instret=%0d expected 0/1", w_pc, w_instret); end
    n_checks++; if (w_ret !== 32'd5 || w_dbg_state !== FETCH) begin n_fail++; $display("FAIL wrap_ret: got ret=%h state=%0d expected 5/%0d", w_ret, w_dbg_state, FETCH); end
  endtask

  task automatic test_reset_mid_fetch();
    logic [31:0] a, iv, wd;
    logic        we;
    do_reset();
    do_inst(32'h0070_0093, 1'b0, 1'b0, 1'b1, 32'd7, a, iv, we, wd);
    imem_req_rdy = 1'b1;
    step();
    imem_req_rdy = 1'b0;
    n_checks++; if (dbg_state !== WAIT || pc !== 32'h8000_0004) begin n_fail++; $display("FAIL mid_pre: got state=%0d pc=%h expected %0d/%h", dbg_state, pc, WAIT, 32'h8000_0004); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (dbg_state !== FETCH || pc !== 32'h8000_0000) begin n_fail++; $display("FAIL mid_async: got state=%0d pc=%h expected %0d/%h", dbg_state, pc, FETCH, 32'h8000_0000); end
    n_checks++; if ({ret, instret, inst} !== 96'd0) begin n_fail++; $display("FAIL mid_regs: got %h expected 0", {ret, instret, inst}); end
    @(negedge clk);
    reset = 1'b1;
    imem_rsp_vld  = 1'b1;
    imem_rsp_data = 32'hDEAD_BEEF;
    step();
    imem_rsp_vld = 1'b0;
    n_checks++; if (dbg_state !== FETCH || inst !== 32'd0) begin n_fail++; $display("FAIL mid_late_rsp: got state=%0d inst=%h expected %0d/0", dbg_state, inst, FETCH); end
    n_checks++; if (imem_req_vld !== 1'b1 || imem_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL mid_refetch: got vld=%b addr=%h expected 1/%h", imem_req_vld, imem_addr, 32'h8000_0000); end
  endtask

  task automatic test_fetch_wait();
`ifdef YPC_FETCH_TIMEOUT_EN
    do_reset();
    imem_req_rdy = 1'b1;
    step();
    imem_req_rdy = 1'b0;
    repeat (253) step();
    n_checks++; if (fault !== 1'b0 || dbg_state !== WAIT) begin n_fail++; $display("FAIL to_before: got fault=%b state=%0d expected 0/%0d", fault, dbg_state, WAIT); end
    step();
    step();
    n_checks++; if (fault !== 1'b1 || dbg_state !== FAULT) begin n_fail++; $display("FAIL to_expire: got fault=%b state=%0d expected 1/%0d", fault, dbg_state, FAULT); end
    do_reset();
    imem_req_rdy = 1'b1;
    step();
    imem_req_rdy = 1'b0;
    repeat (254) step();
    imem_rsp_vld  = 1'b1;
    imem_rsp_data = 32'h0000_0013;
    step();
    imem_rsp_vld = 1'b0;
    n_checks++; if (fault !== 1'b0 || dbg_state !== DECODE || inst !== 32'h0000_0013) begin n_fail++; $display("FAIL to_rsp_wins: got fault=%b state=%0d inst=%h expected 0/%0d/13", fault, dbg_state, inst, DECODE); end
`else
    do_reset();
    imem_req_rdy = 1'b1;
    step();
    imem_req_rdy = 1'b0;
    repeat (300) step();
    n_checks++; if (fault !== 1'b0 || dbg_state !== WAIT) begin n_fail++; $display("FAIL nowdog_wait: got fault=%b state=%0d expected 0/%0d", fault, dbg_state, WAIT); end
    imem_rsp_vld  = 1'b1;
    imem_rsp_data = 32'h0000_0013;
    step();
    imem_rsp_vld = 1'b0;
    n_checks++; if (dbg_state !== DECODE || inst !== 32'h0000_0013) begin n_fail++; $display("FAIL nowdog_rsp: got state=%0d inst=%h expected %0d/13", dbg_state, inst, DECODE); end
`endif
  endtask

  initial begin
    test_reset();
    test_program();
    test_req_backpressure();
    test_illegal();
    test_pc_wrap();
    test_reset_mid_fetch();
    test_fetch_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
